// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_lsu
//  Brief    : MEM-stage load/store unit. Runs one req/ack data-bus transaction
//             per EX/MEM access, stalls the pipeline until it completes, and
//             returns lane-aligned, sign/zero-extended load data.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        flush_i,
  input  logic [2:0]  fun3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output logic [3:0]  dbus_sel_o,
  input  logic        dbus_ack_i,
  input  logic        dbus_err_i,
  input  logic [31:0] dbus_rdata_i,
  output logic [31:0] load_data_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Last counter value of ACCESS before an unanswered request is aborted.
  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic [2:0]        fun3_q, fun3_d;
  logic [1:0]        off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              bus_err_q, bus_err_d;

  logic              w_access;
  logic              w_illegal;
  logic              w_misal;
  logic [3:0]        w_sel;
  logic [31:0]       w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ext;
  logic              w_timeout;
  logic              w_stall;
  logic              w_misal_pulse;

  assign w_access  = mem_valid_i & (mem_read_i | mem_write_i) & ~flush_i;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == C_TO_LAST) && !dbus_ack_i;

  // Classify the incoming access: alignment, fun3 legality, lane enables and store data.
  always_comb begin
    w_illegal = 1'b0;
    w_misal   = 1'b0;
    w_sel     = 4'b1111;
    w_wdata   = wdata_i;
    case (fun3_i)
      3'b000:  ;
      3'b001:  w_misal = addr_i[0];
      3'b010:  w_misal = |addr_i[1:0];
      3'b100:  w_illegal = mem_write_i;
      3'b101:  begin w_illegal = mem_write_i; w_misal = addr_i[0]; end
      default: w_illegal = 1'b1;
    endcase
    case (fun3_i[1:0])
      2'b00: begin
        w_sel   = 4'b0001 << addr_i[1:0];
        w_wdata = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        w_sel   = addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wdata_i[15:0]}};
      end
      default: begin
        w_sel   = 4'b1111;
        w_wdata = wdata_i;
      end
    endcase
  end

  // Pick the addressed lane out of the read word and extend it to 32 bits.
  always_comb begin
    case (off_q)
      2'd0:    w_byte = dbus_rdata_i[7:0];
      2'd1:    w_byte = dbus_rdata_i[15:8];
      2'd2:    w_byte = dbus_rdata_i[23:16];
      default: w_byte = dbus_rdata_i[31:24];
    endcase
    w_half = off_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    case (fun3_q)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'b0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'b0, w_half};
      default: w_ext = dbus_rdata_i;
    endcase
  end

  // Next-state logic: launch, wait for ack/err/timeout, then release the pipeline for one cycle.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    sel_d         = sel_q;
    we_d          = we_q;
    fun3_d        = fun3_q;
    off_d         = off_q;
    cnt_d         = cnt_q;
    load_data_d   = load_data_q;
    bus_err_d     = 1'b0;
    w_stall       = 1'b0;
    w_misal_pulse = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_access) begin
          if (w_misal || w_illegal) begin
            w_misal_pulse = 1'b1;
          end else begin
            w_stall = 1'b1;
            addr_d  = {addr_i[31:2], 2'b00};
            wdata_d = w_wdata;
            sel_d   = w_sel;
            we_d    = mem_write_i;
            fun3_d  = fun3_i;
            off_d   = addr_i[1:0];
            cnt_d   = '0;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        w_stall = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (dbus_err_i || w_timeout) begin
          // A failed store has no load result, so the last load value is kept.
          if (!we_q) load_data_d = '0;
          bus_err_d = 1'b1;
          state_d   = S_DONE;
        end else if (dbus_ack_i) begin
          if (!we_q) load_data_d = w_ext;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and captured-access registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      fun3_q      <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      load_data_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      fun3_q      <= fun3_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign dbus_req_o   = (state_q == S_ACCESS);
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_wdata_o = wdata_q;
  assign dbus_sel_o   = sel_q;
  assign load_data_o  = load_data_q;
  assign bus_err_o    = bus_err_q;
  assign stall_o      = reset_n & w_stall;
  assign misaligned_o = reset_n & w_misal_pulse;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage_lsu
//  Brief    : Directed self-checking bench for mem_stage_lsu.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage_lsu;

  logic        clk;
  logic        reset_n;
  logic        mem_valid_i, mem_read_i, mem_write_i, flush_i;
  logic [2:0]  fun3_i;
  logic [31:0] addr_i, wdata_i;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_sel_o;
  logic        dbus_ack_i, dbus_err_i;
  logic [31:0] dbus_rdata_i;
  logic [31:0] load_data_o;
  logic        stall_o, misaligned_o, bus_err_o;

  int passed = 0;
  int total  = 0;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_valid_i(mem_valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .flush_i(flush_i), .fun3_i(fun3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_sel_o(dbus_sel_o),
    .dbus_ack_i(dbus_ack_i), .dbus_err_i(dbus_err_i), .dbus_rdata_i(dbus_rdata_i),
    .load_data_o(load_data_o), .stall_o(stall_o), .misaligned_o(misaligned_o),
    .bus_err_o(bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are then updated 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    mem_valid_i = 1'b1;
    mem_read_i  = ~we;
    mem_write_i = we;
    fun3_i      = f3;
    addr_i      = a;
    wdata_i     = wd;
  endtask

  task automatic idle_inputs();
    mem_valid_i = 1'b0;
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    flush_i     = 1'b0;
    dbus_ack_i  = 1'b0;
    dbus_err_i  = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    fun3_i = 3'b000; addr_i = '0; wdata_i = '0; dbus_rdata_i = '0;
    idle_inputs();
    #12;
    chk("rst_req", {31'b0, dbus_req_o}, 32'h0);
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    chk("rst_load", load_data_o, 32'h0);
    chk("rst_sel", {28'b0, dbus_sel_o}, 32'h0);
    reset_n = 1'b1;
    tick();

    // 1: LW 0x100, ack on first ACCESS cycle
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    #1;
    chk("lw_idle_stall", {31'b0, stall_o}, 32'h1);
    chk("lw_idle_req", {31'b0, dbus_req_o}, 32'h0);
    tick();
    chk("lw_acc_req", {31'b0, dbus_req_o}, 32'h1);
    chk("lw_acc_stall", {31'b0, stall_o}, 32'h1);
    chk("lw_acc_sel", {28'b0, dbus_sel_o}, 32'hF);
    chk("lw_acc_addr", dbus_addr_o, 32'h0000_0100);
    chk("lw_acc_we", {31'b0, dbus_we_o}, 32'h0);
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'hDEAD_BEEF;
    tick();
    dbus_ack_i = 1'b0;
    #1;
    chk("lw_done_req", {31'b0, dbus_req_o}, 32'h0);
    chk("lw_done_stall", {31'b0, stall_o}, 32'h0);
    chk("lw_done_data", load_data_o, 32'hDEAD_BEEF);
    chk("lw_done_err", {31'b0, bus_err_o}, 32'h0);
    tick();
    idle_inputs();
    #1;
    chk("lw_back_idle_req", {31'b0, dbus_req_o}, 32'h0);

    // 2: LB / LBU at 0x103, rdata top byte 0x80
    issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
    tick();
    chk("lb_sel", {28'b0, dbus_sel_o}, 32'h8);
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'h8012_3456;
    tick();
    dbus_ack_i = 1'b0;
    #1;
    chk("lb_data", load_data_o, 32'hFFFF_FF80);
    tick();
    issue(1'b0, 3'b100, 32'h0000_0103, 32'h0);
    tick();
    dbus_ack_i = 1'b1;
    tick();
    dbus_ack_i = 1'b0;
    #1;
    chk("lbu_data", load_data_o, 32'h0000_0080);
    tick();

    // 3: SH 0x202
    issue(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD);
    tick();
    chk("sh_sel", {28'b0, dbus_sel_o}, 32'hC);
    chk("sh_we", {31'b0, dbus_we_o}, 32'h1);
    chk("sh_wdata", dbus_wdata_o, 32'hABCD_ABCD);
    chk("sh_addr", dbus_addr_o, 32'h0000_0200);
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'h5555_5555;
    tick();
    dbus_ack_i = 1'b0;
    #1;
    chk("sh_keeps_load", load_data_o, 32'h0000_0080);
    tick();
    idle_inputs();

    // 4: misaligned LW 0x101, SH 0x1, illegal fun3 011
    issue(1'b0, 3'b010, 32'h0000_0101, 32'h0);
    #1;
    chk("lw_mis_pulse", {31'b0, misaligned_o}, 32'h1);
    chk("lw_mis_stall", {31'b0, stall_o}, 32'h0);
    tick();
    chk("lw_mis_req", {31'b0, dbus_req_o}, 32'h0);
    issue(1'b1, 3'b001, 32'h0000_0001, 32'h0);
    #1;
    chk("sh_mis_pulse", {31'b0, misaligned_o}, 32'h1);
    chk("sh_mis_stall", {31'b0, stall_o}, 32'h0);
    tick();
    chk("sh_mis_req", {31'b0, dbus_req_o}, 32'h0);
    issue(1'b0, 3'b011, 32'h0000_0000, 32'h0);
    #1;
    chk("ill_f3_pulse", {31'b0, misaligned_o}, 32'h1);
    issue(1'b1, 3'b100, 32'h0000_0000, 32'h0);
    #1;
    chk("ill_sbu_pulse", {31'b0, misaligned_o}, 32'h1);
    idle_inputs();
    #1;
    chk("mis_clear", {31'b0, misaligned_o}, 32'h0);
    tick();

    // 5: timeout after 4 ACCESS cycles, then LH, then err+ack together
    issue(1'b0, 3'b010, 32'h0000_0300, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req_c%0d", i), {31'b0, dbus_req_o}, 32'h1);
      tick();
    end
    chk("to_done_req", {31'b0, dbus_req_o}, 32'h0);
    chk("to_bus_err", {31'b0, bus_err_o}, 32'h1);
    chk("to_load_zero", load_data_o, 32'h0);
    tick();
    chk("to_err_pulse_end", {31'b0, bus_err_o}, 32'h0);
    issue(1'b0, 3'b001, 32'h0000_0106, 32'h0);
    tick();
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'h8001_7FFF;
    tick();
    dbus_ack_i = 1'b0;
    #1;
    chk("lh_data", load_data_o, 32'hFFFF_8001);
    tick();
    issue(1'b0, 3'b010, 32'h0000_0104, 32'h0);
    tick();
    dbus_ack_i = 1'b1; dbus_err_i = 1'b1; dbus_rdata_i = 32'h1111_1111;
    tick();
    dbus_ack_i = 1'b0; dbus_err_i = 1'b0;
    #1;
    chk("errack_bus_err", {31'b0, bus_err_o}, 32'h1);
    chk("errack_load_zero", load_data_o, 32'h0);
    tick();
    idle_inputs();

    // 6a: reset mid-ACCESS
    issue(1'b1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D);
    tick();
    chk("rstmid_req_before", {31'b0, dbus_req_o}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("rstmid_req", {31'b0, dbus_req_o}, 32'h0);
    chk("rstmid_stall", {31'b0, stall_o}, 32'h0);
    chk("rstmid_we", {31'b0, dbus_we_o}, 32'h0);
    chk("rstmid_addr", dbus_addr_o, 32'h0);
    chk("rstmid_wdata", dbus_wdata_o, 32'h0);
    chk("rstmid_sel", {28'b0, dbus_sel_o}, 32'h0);
    idle_inputs();
    #2;
    reset_n = 1'b1;
    tick();

    // 6b: flush in IDLE -> no request
    issue(1'b0, 3'b010, 32'h0000_0500, 32'h0);
    flush_i = 1'b1;
    #1;
    chk("flush_idle_stall", {31'b0, stall_o}, 32'h0);
    tick();
    chk("flush_idle_req", {31'b0, dbus_req_o}, 32'h0);

    // 6c: flush in ACCESS is ignored
    flush_i = 1'b0;
    tick();
    chk("flush_acc_req_start", {31'b0, dbus_req_o}, 32'h1);
    flush_i = 1'b1;
    tick();
    chk("flush_acc_req_held", {31'b0, dbus_req_o}, 32'h1);
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'h0BAD_F00D;
    tick();
    dbus_ack_i = 1'b0;
    #1;
    chk("flush_acc_data", load_data_o, 32'h0BAD_F00D);
    chk("flush_acc_err", {31'b0, bus_err_o}, 32'h0);
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
